// File: rtl/psys_route_pkg.sv
// Shared lane geometry for the 128-bit <-> 1536-bit stream width converters.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package psys_route_pkg;

    localparam int LANE_W = 128;
    localparam int LANES  = 12;
    localparam int WORD_W = LANE_W * LANES;
    localparam int CNT_W  = $clog2(LANES);

    typedef logic [CNT_W-1:0] lane_idx_t;

    // True when the given lane index is the last lane of a word of n lanes.
    function automatic logic lane_is_final(input lane_idx_t idx, input int n);
        return int'(idx) == (n - 1);
    endfunction

endpackage

// File: rtl/in128_out1536.sv
// Packs 128-bit stream beats into twelve-lane 1536-bit words with per-lane tlast.
// Latency: closing beat accepted at edge N -> m_axis_tvalid from N+1 if output is free.
// Backpressure: holds one word in the output plus one closed word in the accumulator, then drops s_axis_tready.
module in128_out1536 #(
    parameter  int IN_WIDTH  = psys_route_pkg::LANE_W,
    parameter  int LANES     = psys_route_pkg::LANES,
    localparam int OUT_WIDTH = IN_WIDTH * LANES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [LANES-1:0]     m_axis_tlast
);
    import psys_route_pkg::*;

    localparam int CW = $clog2(LANES);

    logic [OUT_WIDTH-1:0] acc_data, acc_data_nxt, acc_ins;
    logic [LANES-1:0]     acc_last, acc_last_nxt, last_ins;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 closed, closed_nxt;
    logic [OUT_WIDTH-1:0] out_data, out_data_nxt;
    logic [LANES-1:0]     out_last, out_last_nxt;
    logic                 out_vld, out_vld_nxt;

    logic in_hs;
    logic out_free;
    logic closing;

    // closed is itself a register, so tready is registered and payload-independent.
    assign s_axis_tready = ~closed;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign m_axis_tvalid = out_vld;

    assign in_hs    = s_axis_tvalid & ~closed;
    assign out_free = ~out_vld | m_axis_tready;
    assign closing  = in_hs & ((int'(cnt) == LANES - 1) | s_axis_tlast);

    // Accumulator contents as they would look with the current beat written in.
    always_comb begin
        acc_ins  = acc_data;
        last_ins = acc_last;
        acc_ins[int'(cnt)*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
        last_ins[cnt] = s_axis_tlast;
    end

    always_comb begin
        acc_data_nxt = acc_data;
        acc_last_nxt = acc_last;
        cnt_nxt      = cnt;
        closed_nxt   = closed;
        out_data_nxt = out_data;
        out_last_nxt = out_last;
        out_vld_nxt  = out_vld;

        if (out_vld && m_axis_tready) begin
            out_vld_nxt = 1'b0;
        end

        if (closed) begin
            if (out_free) begin
                out_data_nxt = acc_data;
                out_last_nxt = acc_last;
                out_vld_nxt  = 1'b1;
                acc_data_nxt = '0;
                acc_last_nxt = '0;
                closed_nxt   = 1'b0;
            end
        end else if (in_hs) begin
            if (closing) begin
                cnt_nxt = '0;
                if (out_free) begin
                    // Direct load keeps back-to-back words bubble-free.
                    out_data_nxt = acc_ins;
                    out_last_nxt = last_ins;
                    out_vld_nxt  = 1'b1;
                    acc_data_nxt = '0;
                    acc_last_nxt = '0;
                end else begin
                    acc_data_nxt = acc_ins;
                    acc_last_nxt = last_ins;
                    closed_nxt   = 1'b1;
                end
            end else begin
                acc_data_nxt = acc_ins;
                acc_last_nxt = last_ins;
                cnt_nxt      = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_last <= '0;
            cnt      <= '0;
            closed   <= 1'b0;
            out_data <= '0;
            out_last <= '0;
            out_vld  <= 1'b0;
        end else begin
            acc_data <= acc_data_nxt;
            acc_last <= acc_last_nxt;
            cnt      <= cnt_nxt;
            closed   <= closed_nxt;
            out_data <= out_data_nxt;
            out_last <= out_last_nxt;
            out_vld  <= out_vld_nxt;
        end
    end

endmodule

// File: doc/in128_out1536.md
# in128_out1536

Width upconverter that packs 128-bit AXI-Stream beats into 1536-bit words of twelve 128-bit lanes, carrying per-lane tlast flags. It is the receive-side counterpart of the 1536→128 downsizers behind the inter-switch output ports. It feeds 128-bit sources (DMA read channels) into the 1536-bit switch inputs `s_in_a`/`s_in_b`, whose tlast is 12 bits wide. It sustains one input beat per cycle with no per-word bubble while the downstream side is ready.

## Interface
- `IN_WIDTH`, 128, input beat width.
- `LANES`, 12, beats per output word.
- `OUT_WIDTH`, `IN_WIDTH*LANES` (1536), derived, not overridden.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in `IN_WIDTH`: input beat.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat accepted.
- `s_axis_tlast` in 1: beat ends a packet.
- `m_axis_tdata` out `OUT_WIDTH`: packed word.
  - Lane k is bits `[128k+127:128k]`.
  - The first-received beat is in lane 0.
- `m_axis_tvalid` out 1: word valid.
- `m_axis_tready` in 1: downstream accepts the word.
- `m_axis_tlast` out `LANES`: bit k is set when lane k carried `s_axis_tlast`.

## Operation
- **Accumulator**
  - Holds lanes 0..11, a 12-bit lane-tlast vector, a 4-bit beat counter `cnt` (0..11), and a `closed` flag.
- **Input accept**
  - An input handshake is `s_axis_tvalid & s_axis_tready`.
  - `s_axis_tready = ~closed`, registered. It never depends on input payload or tvalid.
- **Accepted beat**
  - The beat is written to lane `cnt`.
  - Tlast vector bit `cnt` is set to `s_axis_tlast`.
- **Closing beat**
  - A beat closes the word when `cnt==11` or `s_axis_tlast==1`.
  - On a closing beat, `cnt` returns to 0. Otherwise `cnt` increments.
- **Word transfer on a closing beat**
  - The output register is free when `~m_axis_tvalid | m_axis_tready`.
  - If the output register is free in the same cycle, the completed word (including the current beat) loads directly into the output register.
  - Otherwise the word stays in the accumulator and `closed` is set.
- **Pending closed word**
  - While `closed` is set, the accumulator transfers to the output register on the first cycle the output register is free.
  - `closed` clears on that transfer, and `s_axis_tready` returns to 1 on the next cycle.
- **Short packets**
  - Lanes above the closing lane are zero in `m_axis_tdata`. The accumulator zero-clears its lanes on each transfer.
  - `m_axis_tlast` has at most one bit set. It is all zero for a full 12-beat word without tlast.
- **Output stability**
  - The output register holds `m_axis_tdata`/`m_axis_tlast` stable while `m_axis_tvalid & ~m_axis_tready`.
- **Output clear**
  - `m_axis_tvalid` clears after a handshake unless a new word loads in the same cycle.

## Timing
- **Reset values**
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `s_axis_tready=1`.
  - Internal state: `cnt=0`, `closed=0`, accumulator zero.
- **Latency**
  - Closing beat accepted at edge N → `m_axis_tvalid=1` from cycle N+1 when the output register is free.
- **Throughput**
  - 12 accepted beats per output word, back-to-back, with `s_axis_tready` constantly 1 when `m_axis_tready=1`.
- **Simultaneous events**
  - A closing beat arriving in the same cycle as the output handshake loads the new word with no bubble.
  - A pending `closed` word arriving in the same cycle as the output handshake transfers that cycle.
- **Backpressure**
  - With `m_axis_tready=0`, at most one word is held in output plus one closed word in the accumulator.
  - After that, `s_axis_tready=0`.
- **Reset mid-operation**
  - Partial and pending words are discarded.
  - No output word is emitted for them.

## Structure
- Shared package `psys_route_pkg`:
  - `LANE_W=128`, `LANES=12`, `WORD_W=1536`.
  - Beat counter width `$clog2(LANES)`.
  - The in1536_out128 / in1536_out256_flex converters already use these constants.
- Single flat module; no sub-module.
- The output register is a plain one-entry holding stage. The axi_register_slice is not instantiated, because the direct-load path is required for zero-bubble operation.

## Test plan
- **Full word:** 12 beats, beat k = `{16{k[7:0]}}`, no tlast, `m_axis_tready=1`.
  - One word, lane k = beat k.
  - `m_axis_tlast=12'h000`.
  - tvalid rises the cycle after beat 11.
- **Short packet:** 5 beats, tlast on beat 4.
  - Lanes 0..4 carry data; lanes 5..11 are zero.
  - `m_axis_tlast=12'h010`.
  - `cnt` resets; the next beat lands in lane 0.
- **Single-beat packet:** one beat with tlast.
  - `m_axis_tlast=12'h001`; lanes 1..11 are zero.
- **Backpressure:** hold `m_axis_tready=0`, stream 36 beats.
  - Two words are buffered, and `s_axis_tready` falls after beat 24.
  - Release `m_axis_tready` → words emitted in order with data unchanged.
  - `s_axis_tready` returns to 1 one cycle after the accumulator transfer.
- **Back-to-back:** 48 beats continuous with `m_axis_tready=1`.
  - 4 words, `s_axis_tready` never low.
  - Words spaced exactly 12 cycles apart.
- **Async reset:** assert `rst_n` mid-word (after 7 beats) and mid-backpressure.
  - All outputs go to reset values immediately.
  - The next 12 beats form a clean word starting at lane 0.
